fifo_rd_stream: RTL and testbench

Read-side consumer for the asynchronous FIFO controller. It lives entirely in the read clock domain and issues `r_en` against the controller's `r_empty` flag. It captures `r_data` from the synchronous FIFO memory, which has a one-cycle read latency, into a 2-entry skid buffer. It presents the words downstream as a valid/ready stream at full throughput, in order, with no loss or duplication.

---
 rtl/fifo_rd_stream.sv | 74 +++++++
 tb/tb_fifo_rd_stream.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// Read-domain FIFO consumer: r_en -> m_valid in 2 cycles, one word per cycle when m_ready is high.
// Backpressure: buffered+in-flight words never exceed 2, and r_en stalls until a pop. FIFO_RD_CNT_EN adds rd_cnt.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rstn,
  input  logic                  r_empty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            rd_level
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  rd_cnt
`endif
);

  logic                  inflight;
  logic [1:0]            count;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  pop;
  logic [2:0]            occ_next;

  assign m_valid  = (count != 2'd0);
  assign pop      = m_valid & m_ready;
  assign m_data   = buf_q[head];
  assign rd_level = count;

  // Occupancy after this edge if no new read were issued; a read is only launched when its word has a slot.
  assign occ_next = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign r_en     = r_rstn & ~r_empty & (occ_next < 3'd2);

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      head     <= 1'b0;
      tail     <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      inflight <= r_en;
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      if (inflight) begin
        buf_q[tail] <= r_data;
        tail        <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
    end
  end

`ifdef FIFO_RD_CNT_EN
  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      rd_cnt <= '0;
    end else if (pop) begin
      rd_cnt <= rd_cnt + CNT_WIDTH'(1);
    end
  end
`else
  if (CNT_WIDTH < 1) begin : g_cnt_width_chk
    $error("CNT_WIDTH must be at least 1");
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO/memory model plus per-cycle stream checks and directed scenarios.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          r_clk  = 1'b0;
  logic          r_rstn = 1'b1;
  logic          r_empty;
  logic          r_en;
  logic [DW-1:0] r_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [1:0]    rd_level;
`ifdef FIFO_RD_CNT_EN
  logic [CW-1:0] rd_cnt;
`endif

  int checks = 0;
  int passed = 0;

  // Memory contents in write order; words must come out as mem[0], mem[1], ... after each reset.
  logic [DW-1:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  // Totals since reset: reads issued, words landed in the buffer, words accepted downstream.
  int n_rd  = 0;
  int n_cap = 0;
  int n_pop = 0;

  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_dat   = '0;
  int            written, cyc, burst;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .r_clk   (r_clk),
    .r_rstn  (r_rstn),
    .r_empty (r_empty),
    .r_en    (r_en),
    .r_data  (r_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .rd_level(rd_level)
`ifdef FIFO_RD_CNT_EN
    ,
    .rd_cnt  (rd_cnt)
`endif
  );

  always #5 r_clk = ~r_clk;

  assign r_empty = (rd_ptr == wr_ptr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Synchronous memory with one-cycle read latency, plus the running totals of the model.
  always @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      rd_ptr <= 0;
      r_data <= '0;
      n_rd   <= 0;
      n_cap  <= 0;
      n_pop  <= 0;
    end else begin
      if (r_en) begin
        r_data <= mem[rd_ptr % 2048];
        rd_ptr <= rd_ptr + 1;
      end
      n_rd  <= n_rd + (r_en ? 1 : 0);
      n_cap <= n_rd;
      if ((n_cap > n_pop) && m_ready) n_pop <= n_pop + 1;
    end
  end

  always @(negedge r_clk) begin : cmp
    int lvl, inflt, occ;
    lvl   = n_cap - n_pop;
    inflt = n_rd - n_cap;
    occ   = lvl + inflt - (((lvl > 0) && m_ready) ? 1 : 0);
    if (r_rstn) begin
      chk("m_valid", 32'(m_valid), 32'(lvl > 0));
      chk("rd_level", 32'(rd_level), 32'(lvl));
      chk("rd_level_max", 32'(rd_level <= 2'd2), 32'(1));
      chk("r_en", 32'(r_en), 32'((rd_ptr != wr_ptr) && (occ < 2)));
      chk("no_full_inflight", 32'((dut.count == 2'd2) && dut.inflight), 32'(0));
      if (lvl > 0) chk("m_data_order", 32'(m_data), 32'(mem[n_pop % 2048]));
      if (prev_stall) chk("m_data_hold", 32'(m_data), 32'(prev_dat));
`ifdef FIFO_RD_CNT_EN
      chk("rd_cnt", 32'(rd_cnt), 32'(n_pop % 16));
`endif
      prev_stall = m_valid & ~m_ready;
      prev_dat   = m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr % 2048] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(posedge r_clk);
    #1;
    r_rstn  = 1'b0;
    m_ready = 1'b0;
    wr_ptr  = 0;
    repeat (2) @(posedge r_clk);
    #1 r_rstn = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int c = 0;
    while (n_pop < n && c < budget) begin
      @(negedge r_clk);
      c++;
    end
    chk(name, 32'(n_pop), 32'(n));
  endtask

  initial begin
    // Reset values and idle with an empty FIFO
    #1 r_rstn = 1'b0;
    #1;
    chk("rst_r_en", 32'(r_en), 32'(0));
    chk("rst_m_valid", 32'(m_valid), 32'(0));
    chk("rst_m_data", 32'(m_data), 32'(0));
    chk("rst_rd_level", 32'(rd_level), 32'(0));
    @(posedge r_clk);
    #1 r_rstn = 1'b1;
    repeat (20) @(negedge r_clk);
    chk("idle_r_en", 32'(r_en), 32'(0));
    chk("idle_m_valid", 32'(m_valid), 32'(0));
    chk("idle_reads", 32'(n_rd), 32'(0));

    // Full throughput: 0x11..0x18 with m_ready high
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    @(negedge r_clk);
    chk("lat_r_en_n", 32'(r_en), 32'(1));
    chk("lat_valid_n", 32'(m_valid), 32'(0));
    @(negedge r_clk);
    chk("lat_valid_n1", 32'(m_valid), 32'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge r_clk);
      chk("thru_valid", 32'(m_valid), 32'(1));
      chk("thru_data", 32'(m_data), 32'(8'h11 + i));
    end
    @(negedge r_clk);
    chk("thru_drained", 32'(m_valid), 32'(0));
    chk("thru_reads", 32'(n_rd), 32'(8));

    // Backpressure: 10 cycles with m_ready low, then release
    do_reset();
    for (int i = 0; i < 8; i++) push(8'(8'h11 + i));
    repeat (10) @(negedge r_clk);
    chk("bp_reads", 32'(n_rd), 32'(2));
    chk("bp_level", 32'(rd_level), 32'(2));
    chk("bp_data", 32'(m_data), 32'(8'h11));
    chk("bp_r_en", 32'(r_en), 32'(0));
    @(posedge r_clk);
    #1 m_ready = 1'b1;
    @(negedge r_clk);
    chk("bp_head", 32'(m_data), 32'(8'h11));
    wait_pops(8, 40, "bp_all_words");
    chk("bp_total_reads", 32'(n_rd), 32'(8));

    // Random ready and bursty writer over 1000 words
    do_reset();
    written = 0;
    cyc = 0;
    while (n_pop < 1000 && cyc < 20000) begin
      @(posedge r_clk);
      #1;
      cyc++;
      m_ready = 1'($urandom_range(0, 1));
      if (written < 1000 && $urandom_range(0, 2) == 0) begin
        burst = $urandom_range(1, 6);
        for (int k = 0; k < burst && written < 1000; k++) begin
          push(8'($urandom));
          written++;
        end
      end
    end
    chk("rand_all_words", 32'(n_pop), 32'(1000));
    chk("rand_reads", 32'(n_rd), 32'(1000));

    // Reset while one word is buffered and one is in flight
    do_reset();
    for (int i = 0; i < 4; i++) push(8'(8'hA0 + i));
    cyc = 0;
    while (!((n_cap - n_pop == 1) && (n_rd - n_cap == 1)) && cyc < 20) begin
      @(negedge r_clk);
      cyc++;
    end
    chk("mid_level", 32'(rd_level), 32'(1));
    #1 r_rstn = 1'b0;
    wr_ptr = 0;
    #1;
    chk("mid_rst_r_en", 32'(r_en), 32'(0));
    chk("mid_rst_m_valid", 32'(m_valid), 32'(0));
    chk("mid_rst_m_data", 32'(m_data), 32'(0));
    chk("mid_rst_level", 32'(rd_level), 32'(0));
    repeat (2) @(posedge r_clk);
    #1 r_rstn = 1'b1;
    repeat (10) @(negedge r_clk);
    chk("post_rst_valid", 32'(m_valid), 32'(0));
    chk("post_rst_level", 32'(rd_level), 32'(0));

`ifdef FIFO_RD_CNT_EN
    // 18 transfers wrap a 4-bit counter to 2
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) push(8'(i));
    wait_pops(18, 60, "cnt_words");
    @(negedge r_clk);
    chk("cnt_wrap", 32'(rd_cnt), 32'(2));
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
